// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x-baud clock enable (ce_16).
// Serial input is resynchronised, the start bit is confirmed at mid-bit,
// and data/stop bits are sampled every 16 ticks after that point.
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the
// data and stop bits, plus the rx_parity_odd / rx_parity_err ports.
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ce_16,
  input  logic                 ser_in,
`ifdef UART_RX_PARITY_EN
  input  logic                 rx_parity_odd,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 rx_parity_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
`ifdef UART_RX_PARITY_EN
    ,
    S_PARITY
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [3:0]             tick_cnt_q, tick_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_frame_err_q, rx_frame_err_d;
  logic                   rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
  logic                   par_bit_q, par_bit_d;
  logic                   rx_parity_err_q, rx_parity_err_d;
`endif

  logic rx_in;
  logic tick_last;
  logic bit_last;

  assign rx_in     = sync_q[SYNC_STAGES-1];
  assign tick_last = (tick_cnt_q == 4'd15);
  assign bit_last  = (bit_cnt_q == 3'(DATA_BITS - 1));

  // Shift the asynchronous line into the synchroniser chain; idle level is 1.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], ser_in};
  end

  // Register all state; reset discards any frame in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      sync_q         <= '1;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_q       <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      tick_cnt_q     <= tick_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rx_frame_err_q <= rx_frame_err_d;
      rx_busy_q      <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      par_bit_q       <= par_bit_d;
      rx_parity_err_q <= rx_parity_err_d;
`endif
    end
  end

  // Next-state logic; the FSM only moves on clocks carrying a ce_16 tick.
  always_comb begin
    state_d = state_q;
    if (ce_16) begin
      case (state_q)
        S_IDLE:  if (!rx_in) state_d = S_START;
        // A start bit that is no longer low at mid-bit is treated as a glitch.
        S_START: if (tick_cnt_q == 4'd7) state_d = rx_in ? S_IDLE : S_DATA;
        S_DATA: begin
          if (tick_last && bit_last) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: if (tick_last) state_d = S_STOP;
`endif
        S_STOP:  if (tick_last) state_d = rx_in ? S_IDLE : S_BREAK;
        // Stay here while the line is held low so a break cannot restart a frame.
        S_BREAK: if (rx_in) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Counters, shift register and registered output pulses.
  always_comb begin
    tick_cnt_d     = tick_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rx_frame_err_d = 1'b0;
    rx_busy_d      = (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
    par_bit_d       = par_bit_q;
    rx_parity_err_d = 1'b0;
`endif
    if (ce_16) begin
      case (state_q)
        S_IDLE: tick_cnt_d = 4'd0;
        S_START: begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        S_DATA: begin
          // Counter wraps 15->0, so each following bit starts at tick 0.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_last) begin
            shift_d   = {rx_in, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_last) par_bit_d = rx_in;
        end
`endif
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_last) begin
            rx_data_d = shift_q;
            if (rx_in) begin
              rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
              rx_parity_err_d = (par_bit_q != (^shift_q ^ rx_parity_odd));
`endif
            end else begin
              rx_frame_err_d = 1'b1;
            end
          end
        end
        S_BREAK: tick_cnt_d = 4'd0;
        default: tick_cnt_d = 4'd0;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with ce_16 every 4 clocks (64 clocks/bit).
module tb_uart_rx;

  logic       clock;
  logic       reset_n;
  logic       ce_16;
  logic       ser_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_odd;
  logic       rx_parity_err;
`endif

  int n_cmp  = 0;
  int n_bad  = 0;
  int vcyc   = 0;   // clocks with rx_valid high
  int fcyc   = 0;   // clocks with rx_frame_err high
  int both   = 0;   // clocks with both pulses high
  int pcyc   = 0;   // clocks with rx_parity_err high
  int v0, f0;

  uart_rx #(.DATA_BITS(8), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ce_16        (ce_16),
    .ser_in       (ser_in),
`ifdef UART_RX_PARITY_EN
    .rx_parity_odd(rx_parity_odd),
    .rx_parity_err(rx_parity_err),
`endif
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ce_16: one clock high out of every four.
  initial begin
    int div;
    div   = 0;
    ce_16 = 1'b0;
    forever begin
      @(negedge clock);
      ce_16 = (div == 3);
      div   = (div + 1) % 4;
    end
  end

  // Pulse monitor, sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (rx_valid) vcyc++;
      if (rx_frame_err) fcyc++;
      if (rx_valid && rx_frame_err) both++;
`ifdef UART_RX_PARITY_EN
      if (rx_parity_err) pcyc++;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_time(input logic b);
    ser_in = b;
    repeat (64) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
`ifdef UART_RX_PARITY_EN
    bit_time((~^d) ^ par_flip);
`endif
    bit_time(stop_b);
  endtask

  initial begin
    reset_n = 1'b0;
    ser_in  = 1'b1;
`ifdef UART_RX_PARITY_EN
    rx_parity_odd = 1'b1;
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Idle line after reset
    repeat (2000) @(negedge clock);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_valid_cnt", vcyc, 0);
    chk("reset_ferr_cnt", fcyc, 0);
    chk("reset_busy", rx_busy, 1'b0);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, 1'b0);
    repeat (128) @(negedge clock);
    chk("a5_valid_cnt", vcyc, 1);
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_ferr_cnt", fcyc, 0);
    chk("a5_busy", rx_busy, 1'b0);

    // Low glitch lasting 3 ticks
    ser_in = 1'b0;
    repeat (12) @(negedge clock);
    ser_in = 1'b1;
    chk("glitch_busy_hi", rx_busy, 1'b1);
    repeat (200) @(negedge clock);
    chk("glitch_busy_lo", rx_busy, 1'b0);
    chk("glitch_valid_cnt", vcyc, 1);
    chk("glitch_ferr_cnt", fcyc, 0);
    chk("glitch_data", rx_data, 8'hA5);

    // 0x3C with bad stop, then break for 5 bit times, then 0x81
    v0 = vcyc;
    f0 = fcyc;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (320) @(negedge clock);
    chk("ferr_data", rx_data, 8'h3C);
    chk("ferr_ferr_cnt", fcyc - f0, 1);
    chk("ferr_valid_cnt", vcyc - v0, 0);
    chk("break_busy", rx_busy, 1'b1);
    ser_in = 1'b1;
    repeat (128) @(negedge clock);
    chk("break_end_busy", rx_busy, 1'b0);
    chk("break_valid_cnt", vcyc - v0, 0);
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (128) @(negedge clock);
    chk("x81_valid_cnt", vcyc - v0, 1);
    chk("x81_data", rx_data, 8'h81);
    chk("x81_ferr_cnt", fcyc - f0, 1);

    // Reset in the middle of data bit 4 of 0x55
    v0 = vcyc;
    bit_time(1'b0);
    for (int i = 0; i < 4; i++) bit_time(i[0] ? 1'b0 : 1'b1);
    ser_in = 1'b1;
    repeat (32) @(negedge clock);
    chk("pre_rst_busy", rx_busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_busy", rx_busy, 1'b0);
    chk("rst_valid", rx_valid, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (640) @(negedge clock);
    chk("rst_no_pulse", vcyc - v0, 0);
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (128) @(negedge clock);
    chk("x55_valid_cnt", vcyc - v0, 1);
    chk("x55_data", rx_data, 8'h55);

`ifdef UART_RX_PARITY_EN
    // Odd parity: 0x07 has three ones, so the correct parity bit is 0.
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (128) @(negedge clock);
    chk("par_bad_valid_cnt", vcyc - v0, 2);
    chk("par_bad_perr_cnt", pcyc, 1);
    chk("par_bad_data", rx_data, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (128) @(negedge clock);
    chk("par_ok_valid_cnt", vcyc - v0, 3);
    chk("par_ok_perr_cnt", pcyc, 1);
`endif

    chk("never_both", both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
